huffman_decoder_packed: RTL and testbench

Parametrised bit-serial decoder for the team's fixed six-symbol prefix code (A–F), with flow control and word packing. Bits enter one per cycle under a valid/ready handshake. Decoded 3-bit symbols are packed into `SYMS_PER_WORD`-symbol output words, delivered over a second valid/ready handshake. The block sits between a serial bit source and a word-wide consumer, and replaces the unpacked, unflow-controlled decoder.

---
 rtl/huffman_decoder_packed.sv | 146 ++++++++++++++
 tb/tb_huffman_decoder_packed.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder_packed.sv
// Bit-serial decoder for the six-symbol prefix code (A-F), packing 3-bit symbols into SYMS_PER_WORD-slot words; optional flush via HUFFMAN_DEC_FLUSH_EN.
// Latency: a symbol enters the packer on the edge accepting its last bit; a completed word is valid the following cycle.
// Backpressure: x_ready drops only while the output word is stalled and the packer holds SYMS_PER_WORD-1 symbols (or while flushing).
module huffman_decoder_packed #(
  parameter int SYMS_PER_WORD = 4,
  parameter int CNT_W         = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   x,
  input  logic                                   x_valid,
  output logic                                   x_ready,
  output logic [3*SYMS_PER_WORD-1:0]             word,
  output logic [$clog2(SYMS_PER_WORD+1)-1:0]     word_count,
  output logic                                   word_valid,
  input  logic                                   word_ready,
`ifdef HUFFMAN_DEC_FLUSH_EN
  input  logic                                   flush,
`endif
  output logic [CNT_W-1:0]                       sym_count
);

  localparam int CW = $clog2(SYMS_PER_WORD + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SYMS_PER_WORD - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(SYMS_PER_WORD);

  typedef enum logic [2:0] {ROOT, P1, P10, P11, P110} state_t;

  state_t                            r_state, w_state_nxt;
  logic [CW-1:0]                     r_fill;
  logic [SYMS_PER_WORD-1:0][2:0]     r_slots, w_slots_ins;
  logic [3*SYMS_PER_WORD-1:0]        r_word;
  logic [CW-1:0]                     r_word_count;
  logic                              r_word_valid;
  logic [CNT_W-1:0]                  r_sym_count;

  logic       w_flush_req, w_flush_go, w_out_free, w_acc;
  logic       w_emit, w_full, w_load;
  logic [2:0] w_sym;

`ifdef HUFFMAN_DEC_FLUSH_EN
  assign w_flush_req = flush;
`else
  assign w_flush_req = 1'b0;
`endif

  assign w_out_free = !r_word_valid || word_ready;
  assign x_ready    = !(r_word_valid && !word_ready && (r_fill == LAST_SLOT)) && !w_flush_req;
  assign w_acc      = x_valid && x_ready;
  assign w_flush_go = w_flush_req && w_out_free;

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_sym       = 3'd0;
    if (w_flush_go) begin
      w_state_nxt = ROOT;
    end else if (w_acc) begin
      case (r_state)
        ROOT: begin
          if (x) w_state_nxt = P1;
          else begin
            w_emit = 1'b1;
            w_sym  = 3'd1;
          end
        end
        P1:   w_state_nxt = x ? P11 : P10;
        P10: begin
          w_emit      = 1'b1;
          w_sym       = x ? 3'd2 : 3'd3;
          w_state_nxt = ROOT;
        end
        P11: begin
          if (x) begin
            w_emit      = 1'b1;
            w_sym       = 3'd4;
            w_state_nxt = ROOT;
          end else begin
            w_state_nxt = P110;
          end
        end
        P110: begin
          w_emit      = 1'b1;
          w_sym       = x ? 3'd5 : 3'd6;
          w_state_nxt = ROOT;
        end
        default: w_state_nxt = ROOT;
      endcase
    end
  end

  // Packer contents including the symbol emitted this cycle, if any.
  always_comb begin
    w_slots_ins = r_slots;
    for (int i = 0; i < SYMS_PER_WORD; i++) begin
      if (w_emit && (r_fill == CW'(i))) w_slots_ins[i] = w_sym;
    end
  end

  assign w_full = w_emit && (r_fill == LAST_SLOT);
  assign w_load = w_full || (w_flush_go && (r_fill != '0));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ROOT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill  <= '0;
      r_slots <= '0;
    end else if (w_full || w_flush_go) begin
      r_fill  <= '0;
      r_slots <= '0;
    end else if (w_emit) begin
      r_fill  <= r_fill + CW'(1);
      r_slots <= w_slots_ins;
    end
  end

  // A load can only coincide with a free or draining output register, so it never overwrites an untaken word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word       <= '0;
      r_word_count <= '0;
      r_word_valid <= 1'b0;
    end else if (w_load) begin
      r_word       <= w_slots_ins;
      r_word_count <= w_full ? FULL_CNT : r_fill;
      r_word_valid <= 1'b1;
    end else if (word_ready) begin
      r_word_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       r_sym_count <= '0;
    else if (w_emit) r_sym_count <= r_sym_count + CNT_W'(1);
  end

  assign word       = r_word;
  assign word_count = r_word_count;
  assign word_valid = r_word_valid;
  assign sym_count  = r_sym_count;

endmodule

// File: tb/tb_huffman_decoder_packed.sv
// Scoreboard bench for huffman_decoder_packed: a string-matching code-table model feeds an expected-word queue.
module tb_huffman_decoder_packed;
  localparam int S     = 4;
  localparam int CW    = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, x, x_valid, x_ready, word_valid, word_ready;
  logic [3*S-1:0]    word;
  logic [CW-1:0]     word_count;
  logic [CNT_W-1:0]  sym_count;
  logic              flush_eff;
`ifdef HUFFMAN_DEC_FLUSH_EN
  logic              flush;
  assign flush_eff = flush;
`else
  assign flush_eff = 1'b0;
`endif

  huffman_decoder_packed #(.SYMS_PER_WORD(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .word(word), .word_count(word_count), .word_valid(word_valid), .word_ready(word_ready),
`ifdef HUFFMAN_DEC_FLUSH_EN
    .flush(flush),
`endif
    .sym_count(sym_count)
  );

  typedef struct packed { logic [3*S-1:0] w; logic [CW-1:0] c; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  string m_bits = "";
  int    m_syms[$];
  int    m_cnt = 0;
  bit    m_out_valid = 0;
  bit    m_new_word;
  logic [3*S-1:0] last_word = '0;
  logic [CW-1:0]  last_count = '0;
  int    cyc = 0;

  bit s_ok = 0, s_reset, s_acc, s_bit, s_rdy, s_flush;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int code_of(input string s);
    if (s == "0")    return 1;
    if (s == "101")  return 2;
    if (s == "100")  return 3;
    if (s == "111")  return 4;
    if (s == "1101") return 5;
    if (s == "1100") return 6;
    return 0;
  endfunction

  function automatic void push_word();
    exp_t e;
    int   v;
    v = 0;
    foreach (m_syms[i]) v = v + m_syms[i] * (1 << (3 * i));
    e.w = (3*S)'(v);
    e.c = CW'(m_syms.size());
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: applies the handshakes sampled on the preceding falling edge.
  always @(posedge clk) begin
    if (s_ok) begin
      if (s_reset) begin
        m_bits = ""; m_syms.delete(); m_cnt = 0; m_out_valid = 0; exp_q.delete();
      end else begin
        m_new_word = 0;
        if (s_flush && (!m_out_valid || s_rdy)) begin
          if (m_syms.size() > 0) begin push_word(); m_new_word = 1; end
          m_syms.delete(); m_bits = "";
        end else if (s_acc) begin
          m_bits = {m_bits, s_bit ? "1" : "0"};
          if (code_of(m_bits) != 0) begin
            m_syms.push_back(code_of(m_bits));
            m_cnt++;
            m_bits = "";
            if (m_syms.size() == S) begin push_word(); m_syms.delete(); m_new_word = 1; end
          end
        end
        if (m_new_word) m_out_valid = 1;
        else if (s_rdy) m_out_valid = 0;
      end
    end
  end

  // Monitor: compares outputs against the model and pops expected words on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("word_valid", 32'(word_valid), 32'(m_out_valid));
      chk("x_ready", 32'(x_ready),
          32'(!(m_out_valid && !word_ready && m_syms.size() == S-1) && !flush_eff));
      chk("sym_count", 32'(sym_count), 32'(m_cnt % (1 << CNT_W)));
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word: got %0h expected none", word);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'(word), 32'(e.w));
          chk("word_count", 32'(word_count), 32'(e.c));
          last_word  = word;
          last_count = word_count;
        end
      end
    end
    s_reset = reset; s_acc = x_valid && x_ready; s_bit = x; s_rdy = word_ready;
    s_flush = flush_eff; s_ok = 1;
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input bit b);
    int n = 0;
    x = b; x_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (x_ready) begin @(posedge clk); #1; break; end
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL send_timeout: x_ready stuck at %0b required 1", x_ready);
        @(posedge clk); #1; break;
      end
    end
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      if (max_gap > 0) begin
        x_valid = 1'b0;
        cycles($urandom_range(0, max_gap));
      end
      send_bit(s[i] == 8'h31);
    end
    x_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; cycles(n); reset = 1'b0;
  endtask

  int t0;

  initial begin
    reset = 1'b1; x = 1'b0; x_valid = 1'b0; word_ready = 1'b1;
`ifdef HUFFMAN_DEC_FLUSH_EN
    flush = 1'b0;
`endif
    cycles(2);
    reset = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("rst_word", 32'(word), 0);
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_sym_count", 32'(sym_count), 0);
    chk("rst_x_ready", 32'(x_ready), 1);
    @(posedge clk); #1;

    // Reset in the middle of a code discards the partial bits.
    send_str("11", 0);
    do_reset(1);
    send_str("0", 0);
    @(negedge clk); chk("rst_mid_cnt", 32'(sym_count), 1); @(posedge clk); #1;

    do_reset(1);
    t0 = cyc;
    send_str("0101100111", 0);
    chk("throughput_cycles", 32'(cyc - t0), 10);
    cycles(2);
    chk("table_word1", 32'(last_word), 32'h8d1);
    chk("table_count1", 32'(last_count), 4);
    send_str("1101110000", 0);
    cycles(2);
    chk("table_word2", 32'(last_word), 32'h275);
    @(negedge clk); chk("table_syms", 32'(sym_count), 8); @(posedge clk); #1;

    // Backpressure: first word held, packer fills to three, then input stalls.
    word_ready = 1'b0;
    send_str("0000", 0);
    send_str("000", 0);
    x = 1'b0; x_valid = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("bp_x_ready", 32'(x_ready), 0);
    chk("bp_word_hold", 32'(word), 32'h249);
    @(posedge clk); #1;
    word_ready = 1'b1; cycles(1); word_ready = 1'b0; x_valid = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("bp_word2_valid", 32'(word_valid), 1);
    chk("bp_word2", 32'(word), 32'h249);
    @(posedge clk); #1;
    word_ready = 1'b1; cycles(2);

    send_str("1101110011110101", 2);
    cycles(2);
    chk("gapped_word", 32'(last_word), 32'h535);

    do_reset(1);
    for (int i = 0; i < 17; i++) send_str("0", 0);
    cycles(1);
    @(negedge clk); chk("wrap_cnt", 32'(sym_count), 1); @(posedge clk); #1;

`ifdef HUFFMAN_DEC_FLUSH_EN
    do_reset(1);
    send_str("010111", 0);
    flush = 1'b1; cycles(1); flush = 1'b0;
    cycles(2);
    chk("flush_word", 32'(last_word), 32'h011);
    chk("flush_count", 32'(last_count), 2);
    send_str("0", 0);
    @(negedge clk); chk("flush_then_a", 32'(sym_count), 3); @(posedge clk); #1;
`endif

    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      x_valid    = ($urandom_range(0, 3) != 0);
      x          = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 299) == 0);
`ifdef HUFFMAN_DEC_FLUSH_EN
      flush      = ($urandom_range(0, 39) == 0);
`endif
      cycles(1);
    end
    reset = 1'b0; x_valid = 1'b0; word_ready = 1'b1;
`ifdef HUFFMAN_DEC_FLUSH_EN
    flush = 1'b0;
`endif
    cycles(3);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
